stream_fork_using_fifos: RTL

- Fork counterpart of the two-input join/adder stream block: one valid/ready input stream is broadcast to two independent valid/ready output streams.
- Three internal FIFOs, all of the same width/depth:
  - one input FIFO;
  - one output FIFO per branch.
- A word leaves the input FIFO only when both output FIFOs can take it, so both consumers see the identical sequence.
- Sits between a single producer and two consumers that stall independently.

---
 rtl/stream_fork_using_fifos.sv | 102 ++++++++++
 1 files changed

// File: rtl/stream_fork_using_fifos.sv
// stream_fork_using_fifos: broadcast one valid/ready stream to two independently stalling branches via three FIFOs.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data producer side;
// a_valid/a_ready/a_data and b_valid/b_ready/b_data consumer branches.
// Optional STREAM_FORK_USING_FIFOS_STATS_EN adds in_count/a_count/b_count handshake counters.
module stream_fork_using_fifos_fifo #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int aw = depth > 1 ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wp, rp;
  logic [cw-1:0] cnt;
  logic do_push, do_pop;
  always_comb begin
    full = cnt == cw'(depth);
    empty = cnt == '0;
    do_push = push & ~full;
    do_pop = pop & ~empty;
    rdata = mem[rp];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp == aw'(depth - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == aw'(depth - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + cw'(do_push) - cw'(do_pop);
    end
  end
endmodule

module stream_fork_using_fifos #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [width-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [width-1:0] b_data
`ifdef STREAM_FORK_USING_FIFOS_STATS_EN
  ,
  output logic [15:0]      in_count,
  output logic [15:0]      a_count,
  output logic [15:0]      b_count
`endif
);
  logic full_in, empty_in, full_a, empty_a, full_b, empty_b, xfer;
  logic [width-1:0] head;
  // Transfer only when both branches can take the word, keeping them in lockstep.
  always_comb begin
    in_ready = ~full_in;
    xfer = ~empty_in & ~full_a & ~full_b;
    a_valid = ~empty_a;
    b_valid = ~empty_b;
  end
  stream_fork_using_fifos_fifo #(.width(width), .depth(depth)) u_in (
    .clk(clk), .rst(rst), .push(in_valid), .pop(xfer), .wdata(in_data),
    .rdata(head), .full(full_in), .empty(empty_in)
  );
  stream_fork_using_fifos_fifo #(.width(width), .depth(depth)) u_a (
    .clk(clk), .rst(rst), .push(xfer), .pop(a_ready), .wdata(head),
    .rdata(a_data), .full(full_a), .empty(empty_a)
  );
  stream_fork_using_fifos_fifo #(.width(width), .depth(depth)) u_b (
    .clk(clk), .rst(rst), .push(xfer), .pop(b_ready), .wdata(head),
    .rdata(b_data), .full(full_b), .empty(empty_b)
  );
`ifdef STREAM_FORK_USING_FIFOS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      in_count <= '0;
      a_count <= '0;
      b_count <= '0;
    end else begin
      in_count <= in_count + 16'(in_valid & in_ready);
      a_count <= a_count + 16'(a_valid & a_ready);
      b_count <= b_count + 16'(b_valid & b_ready);
    end
  end
`endif
endmodule
